fetch_queue: RTL and testbench

Instruction-supply side of the core's decode interface. Issues word-aligned reads to instruction memory and buffers returned words with their PCs in a small in-order queue. Presents one instruction per cycle to decode through a valid/ready handshake; decode slices op, funct3 and funct7b5 from it. Redirects (taken branch or jump) flush the queue and restart fetch at a new PC.

---
 rtl/fetch_queue.sv | 127 ++++++++++++
 tb/tb_fetch_queue.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: issues word-aligned imem reads, buffers {pc, word} in order.
// Ports: clk/reset, imem req/rsp, redirect/redirect_pc, instr valid/ready/instr/instr_pc.
module fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW+1:0] DEPTH_W = (CW+2)'(DEPTH);
  localparam logic [AW-1:0] ONE_A = AW'(1);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [31:0]   pc_mem_q [DEPTH];
  logic [31:0]   pc_mem_d [DEPTH];
  logic [31:0]   word_mem_q [DEPTH];
  logic [31:0]   word_mem_d [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW+1:0] occ;
  logic          req_fire;
  logic          pop;
  logic          push;
  logic          rsp_drop;
  logic [31:0]   tgt_pc;

  always_comb begin
    occ = {2'b00, count_q} + {2'b00, outst_q} + {2'b00, drop_q};
    // Reserve a slot per outstanding read so responses never need backpressure.
    imem_req_valid = !reset && !redirect && (occ < DEPTH_W);
    imem_addr      = fetch_pc_q;
    instr_valid    = !reset && (count_q != '0);
    instr          = word_mem_q[head_q];
    instr_pc       = pc_mem_q[head_q];
    req_fire       = imem_req_valid && imem_req_ready;
    pop            = instr_valid && instr_ready;
    rsp_drop       = imem_rsp_valid && (drop_q != '0);
    push           = imem_rsp_valid && (drop_q == '0);
    tgt_pc         = redirect_pc & 32'hFFFF_FFFC;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    pc_mem_d   = pc_mem_q;
    word_mem_d = word_mem_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    if (redirect) begin
      fetch_pc_d = tgt_pc;
      rsp_pc_d   = tgt_pc;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      outst_d    = '0;
      // A response landing this cycle already retires one in-flight read.
      drop_d     = drop_q + outst_q - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (rsp_drop) begin
        drop_d = drop_q - ONE_C;
      end
      // Kept responses come back in order, so their PCs run sequentially.
      if (push) begin
        pc_mem_d[tail_q]   = rsp_pc_q;
        word_mem_d[tail_q] = imem_rsp_data;
        tail_d             = tail_q + ONE_A;
        rsp_pc_d           = rsp_pc_q + 32'd4;
      end
      if (pop) begin
        head_d = head_q + ONE_A;
      end
      outst_d = outst_q + CW'(req_fire) - CW'(push);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    pc_mem_q   <= pc_mem_d;
    word_mem_q <= word_mem_d;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: fetch_queue against an in-order memory model and a queue-level
// reference model; directed steps followed by a randomized phase.
module tb_fetch_queue;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'hFFFF_FFF8;
  localparam logic [31:0] KEY   = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  fetch_queue #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] epc;
    int          due;
    bit          stale;
  } mreq_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } ent_t;

  mreq_t       mem[$];
  ent_t        mq[$];
  logic [31:0] issued[$];
  logic [31:0] deliv[$];
  logic [31:0] m_pc;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          lat_lo = 1;
  int          lat_hi = 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check settled outputs, advance models.
  task automatic step(input bit rst, input bit redir, input logic [31:0] rpc,
                      input bit rdy, input bit mrdy);
    bit    rsp, exp_rv, exp_iv, fire, keep;
    mreq_t h, t;
    ent_t  e;
    @(negedge clk);
    reset          = rst;
    redirect       = redir;
    redirect_pc    = rpc;
    instr_ready    = rdy;
    imem_req_ready = mrdy;
    rsp = !rst && mem.size() > 0 && mem[0].due <= cyc;
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? (mem[0].addr ^ KEY) : $urandom;
    #1;
    exp_rv = !rst && !redir && (mq.size() + mem.size() < DEPTH);
    exp_iv = !rst && mq.size() > 0;
    chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    if (exp_rv && imem_req_valid) chk("imem_addr", imem_addr, m_pc);
    chk("instr_valid", 32'(instr_valid), 32'(exp_iv));
    if (exp_iv && instr_valid) begin
      chk("instr", instr, mq[0].word);
      chk("instr_pc", instr_pc, mq[0].pc);
    end
    fire = !rst && imem_req_valid && mrdy;
    if (fire) issued.push_back(imem_addr);
    if (!rst && !redir && instr_valid && rdy) deliv.push_back(instr_pc);
    if (rst) begin
      mem.delete();
      mq.delete();
      m_pc = RPC;
    end else begin
      keep = 1'b0;
      if (rsp) begin
        h = mem.pop_front();
        keep = !redir && !h.stale;
      end
      if (redir) begin
        mq.delete();
        for (int i = 0; i < mem.size(); i++) begin
          t = mem[i];
          t.stale = 1'b1;
          mem[i] = t;
        end
        m_pc = rpc & 32'hFFFF_FFFC;
      end else begin
        if (exp_iv && rdy) void'(mq.pop_front());
        if (keep) begin
          e.pc   = h.epc;
          e.word = h.epc ^ KEY;
          mq.push_back(e);
        end
      end
      if (fire) begin
        t.addr  = imem_addr;
        t.epc   = m_pc;
        t.due   = cyc + int'($urandom_range(lat_hi, lat_lo));
        t.stale = 1'b0;
        mem.push_back(t);
        m_pc = m_pc + 32'd4;
      end
    end
    chk("inflight_bound", 32'(mem.size() <= DEPTH), 32'd1);
    cyc++;
  endtask

  initial begin
    int n0, d0;
    bit found;
    reset          = 1'b1;
    redirect       = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    m_pc           = RPC;

    repeat (2) step(1, 0, 0, 0, 1);

    // Address wrap from RESET_PC near the top of memory.
    n0 = issued.size();
    d0 = deliv.size();
    repeat (10) step(0, 0, 0, 1, 1);
    chk("wrap_a0", issued[n0], 32'hFFFF_FFF8);
    chk("wrap_a1", issued[n0+1], 32'hFFFF_FFFC);
    chk("wrap_a2", issued[n0+2], 32'h0000_0000);
    chk("wrap_p2", deliv[d0+2], 32'h0000_0000);

    // Backpressure at PC 0.
    step(0, 1, 32'h0000_0003, 1, 1);
    n0 = issued.size();
    d0 = deliv.size();
    repeat (10) step(0, 0, 0, 0, 1);
    chk("bp_issued", 32'(issued.size() - n0), 32'd2);
    chk("bp_deliv", 32'(deliv.size() - d0), 32'd0);
    @(posedge clk);
    #1;
    chk("bp_req_valid", 32'(imem_req_valid), 32'd0);
    chk("bp_hold_pc", instr_pc, 32'h0);
    repeat (10) step(0, 0, 0, 1, 1);
    chk("bp_p0", deliv[d0], 32'h0);
    chk("bp_p1", deliv[d0+1], 32'h4);
    chk("bp_p2", deliv[d0+2], 32'h8);

    // Redirect with two reads in flight, 3-cycle memory.
    lat_lo = 3;
    lat_hi = 3;
    step(0, 1, 32'h0000_0200, 1, 1);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    chk("rd_inflight", 32'(mem.size()), 32'd2);
    n0 = issued.size();
    d0 = deliv.size();
    step(0, 1, 32'h0000_0103, 1, 1);
    repeat (14) step(0, 0, 0, 1, 1);
    chk("rd_addr", issued[n0], 32'h0000_0100);
    chk("rd_pc", deliv[d0], 32'h0000_0100);

    // Redirect on a cycle with an arriving response and a pop.
    lat_lo = 1;
    lat_hi = 1;
    found = 1'b0;
    d0 = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (mem.size() > 0 && mem[0].due <= cyc && mq.size() > 0) begin
        found = 1'b1;
        step(0, 1, 32'h0000_0040, 1, 1);
        d0 = deliv.size();
      end else begin
        step(0, 0, 0, 1, 1);
      end
    end
    chk("co_found", 32'(found), 32'd1);
    repeat (8) step(0, 0, 0, 1, 1);
    chk("co_pc", deliv[d0], 32'h0000_0040);

    // Randomized traffic with redirects.
    lat_lo = 1;
    lat_hi = 4;
    repeat (500)
      step(0, $urandom_range(15, 0) == 0, $urandom,
           $urandom_range(3, 0) != 0, $urandom_range(3, 0) != 0);

    // Reset with a full queue.
    lat_lo = 1;
    lat_hi = 1;
    step(0, 1, 32'h0000_0080, 0, 1);
    repeat (6) step(0, 0, 0, 0, 1);
    chk("rs_full", 32'(mq.size()), 32'd2);
    step(1, 0, 0, 1, 1);
    @(posedge clk);
    #1;
    chk("rs_iv", 32'(instr_valid), 32'd0);
    chk("rs_rv", 32'(imem_req_valid), 32'd0);
    step(1, 0, 0, 1, 1);
    n0 = issued.size();
    repeat (4) step(0, 0, 0, 1, 1);
    chk("rs_restart", issued[n0], RPC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
